membus_arbiter: RTL

MEMBUS_ARBITER -- requirements
Module: membus_arbiter

---
 rtl/membus_pkg.sv | 18 +
 rtl/membus_rr_pick.sv | 33 +++
 rtl/membus_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/membus_pkg.sv
// Shared constants for the memory-bus arbiter slice: bus widths and master port indices.
package membus_pkg;

    localparam int unsigned MEMBUS_ADDR_WIDTH  = 18;
    localparam int unsigned MEMBUS_DATA_WIDTH  = 32;
    localparam int unsigned MEMBUS_BSEL_WIDTH  = MEMBUS_DATA_WIDTH / 8;
    localparam int unsigned MEMBUS_NUM_MASTERS = 3;

    localparam int unsigned MEMBUS_M_CPU    = 0;
    localparam int unsigned MEMBUS_M_LAYER1 = 1;
    localparam int unsigned MEMBUS_M_LAYER2 = 2;

    // Round-robin successor among fetcher ports 1..num-1 (wraps back to 1).
    function automatic int unsigned membus_rr_next(input int unsigned idx, input int unsigned num);
        return (idx + 1 >= num) ? 1 : idx + 1;
    endfunction

endpackage

// File: rtl/membus_rr_pick.sv
// Round-robin picker over the fetcher ports 1..NUM_MASTERS-1.
// Only built when MEMBUS_RR_EN is defined. Bit k of req/gnt_c is fetcher port k+1;
// ptr holds the absolute port number (1..NUM_MASTERS-1) that has first claim.
`ifdef MEMBUS_RR_EN
module membus_rr_pick #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned IDX_W       = 2
) (
    input  logic [NUM_MASTERS-2:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_MASTERS-2:0] gnt_c
);

    localparam int unsigned NUM_FETCH = NUM_MASTERS - 1;

    // Scan fetchers starting at ptr, first requester wins.
    always_comb begin
        int unsigned pos;
        logic        found;
        gnt_c = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned off = 0; off < NUM_FETCH; off++) begin
            pos = (32'(ptr) - 1 + off) % NUM_FETCH;
            if (!found && req[pos]) begin
                gnt_c[pos] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/membus_arbiter.sv
// Single-cycle memory bus arbiter: combinational grant, registered one-cycle ack.
// Port 0 (CPU) has absolute priority; fetcher ports use fixed lowest-index priority,
// or round-robin when MEMBUS_RR_EN is defined.
module membus_arbiter
    import membus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = MEMBUS_NUM_MASTERS,
    parameter int unsigned ADDR_WIDTH  = MEMBUS_ADDR_WIDTH
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_MASTERS-1:0]                   m_strobe,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]        m_addr,
    input  logic [NUM_MASTERS-1:0]                   m_write,
    input  logic [NUM_MASTERS*MEMBUS_DATA_WIDTH-1:0] m_wrdata,
    input  logic [NUM_MASTERS*MEMBUS_BSEL_WIDTH-1:0] m_bytesel,
    output logic [NUM_MASTERS-1:0]                   m_ack,
    output logic [MEMBUS_DATA_WIDTH-1:0]             m_rddata,
    output logic                                     mem_strobe,
    output logic [ADDR_WIDTH-1:0]                    mem_addr,
    output logic                                     mem_write,
    output logic [MEMBUS_DATA_WIDTH-1:0]             mem_wrdata,
    output logic [MEMBUS_BSEL_WIDTH-1:0]             mem_bytesel,
    input  logic [MEMBUS_DATA_WIDTH-1:0]             mem_rddata
);

    localparam int unsigned IDX_W = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] ack_q;
    logic [NUM_MASTERS-1:0] elig_c;
    logic [NUM_MASTERS-1:0] fetch_gnt_c;
    logic [NUM_MASTERS-1:0] gnt_c;

    // A master being acked this cycle must not be re-issued until the next one.
    assign elig_c = m_strobe & ~ack_q;

`ifdef MEMBUS_RR_EN
    logic [IDX_W-1:0]       ptr_q;
    logic [IDX_W-1:0]       ptr_next_c;
    logic [NUM_MASTERS-2:0] rr_gnt_c;

    membus_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_rr_pick (
        .req   (elig_c[NUM_MASTERS-1:1]),
        .ptr   (ptr_q),
        .gnt_c (rr_gnt_c)
    );

    assign fetch_gnt_c = {rr_gnt_c, 1'b0};

    // Pointer moves just past the fetcher that won this cycle.
    always_comb begin
        ptr_next_c = ptr_q;
        for (int unsigned i = 1; i < NUM_MASTERS; i++) begin
            if (gnt_c[i]) begin
                ptr_next_c = IDX_W'(membus_rr_next(i, NUM_MASTERS));
            end
        end
    end

    // Round-robin pointer register, restarts at the first fetcher.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDX_W'(1);
        end else begin
            ptr_q <= ptr_next_c;
        end
    end
`else
    // Fixed priority among fetchers: lowest eligible index wins.
    always_comb begin
        fetch_gnt_c = '0;
        for (int i = NUM_MASTERS - 1; i >= 1; i--) begin
            if (elig_c[i]) begin
                fetch_gnt_c = NUM_MASTERS'(1) << i;
            end
        end
    end
`endif

    // CPU port overrides any fetcher; nothing is granted while reset is held.
    always_comb begin
        gnt_c = '0;
        if (rst_n) begin
            gnt_c = elig_c[0] ? NUM_MASTERS'(1) : fetch_gnt_c;
        end
    end

    // One-hot mux of the granted master onto the memory side; all zero when idle.
    always_comb begin
        mem_strobe  = |gnt_c;
        mem_addr    = '0;
        mem_write   = 1'b0;
        mem_wrdata  = '0;
        mem_bytesel = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gnt_c[i]) begin
                mem_addr    = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_write   = m_write[i];
                mem_wrdata  = m_wrdata[i*MEMBUS_DATA_WIDTH +: MEMBUS_DATA_WIDTH];
                mem_bytesel = m_bytesel[i*MEMBUS_BSEL_WIDTH +: MEMBUS_BSEL_WIDTH];
            end
        end
    end

    // Ack is the grant delayed by one cycle; reset drops any in-flight ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= '0;
        end else begin
            ack_q <= gnt_c;
        end
    end

    assign m_ack    = ack_q;
    assign m_rddata = rst_n ? mem_rddata : '0;

endmodule
